// File: rtl/uart_xbar_pkg.sv
// Shared constants for the UART line crossbar: register map, CTRL layout,
// reset values, monitor states and small counter/parity helpers.
package uart_xbar_pkg;

    localparam logic [7:0] ADDR_CTRL       = 8'h00;
    localparam logic [7:0] ADDR_DIV        = 8'h04;
    localparam logic [7:0] ADDR_ROUTE_BASE = 8'h08;
    localparam logic [7:0] ADDR_STAT_BASE  = 8'h40;

    localparam int CTRL_W         = 6;
    localparam int CTRL_MON_EN    = 0;
    localparam int CTRL_DBITS_LSB = 1;
    localparam int CTRL_PAR_EN    = 3;
    localparam int CTRL_PAR_ODD   = 4;
    localparam int CTRL_STOP2     = 5;

    localparam logic [CTRL_W-1:0] CTRL_RESET = 6'h06;
    localparam int                DIV_RESET  = 16;
    localparam int                DIV_MIN    = 4;

    typedef logic [2:0] mon_state_t;
    localparam mon_state_t MON_IDLE   = 3'd0;
    localparam mon_state_t MON_START  = 3'd1;
    localparam mon_state_t MON_DATA   = 3'd2;
    localparam mon_state_t MON_PARITY = 3'd3;
    localparam mon_state_t MON_STOP   = 3'd4;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Expected parity bit given the XOR of the data bits.
    function automatic logic parity_bit(input logic data_xor, input logic odd);
        return data_xor ^ odd;
    endfunction

endpackage

// File: rtl/uart_frame_mon.sv
// Per-channel UART frame monitor: line synchroniser, frame FSM with
// shadowed format/divisor, and saturating frame/framing/parity counters.
module uart_frame_mon
    import uart_xbar_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              line,
    input  logic              mon_en,
    input  logic [CTRL_W-1:0] ctrl,
    input  logic [DIV_W-1:0]  div,
    input  logic              clr,
    output logic [15:0]       frames,
    output logic [7:0]        ferrs,
    output logic [7:0]        perrs,
    output logic              frame_err
);

    logic              sync1_r, sync2_r;
    mon_state_t        state_r, state_s;
    logic [DIV_W-1:0]  cnt_r, cnt_s;
    logic [2:0]        bit_idx_r, bit_idx_s;
    logic              par_r, par_s;
    logic              stop_idx_r, stop_idx_s;
    logic              ferr_seen_r, ferr_seen_s;
    logic [CTRL_W-1:0] sh_ctrl_r, sh_ctrl_s;
    logic [DIV_W-1:0]  sh_div_r, sh_div_s;
    logic              err_r, err_s;
    logic              inc_frame_s, inc_ferr_s, inc_perr_s;
    logic [2:0]        last_bit_s;
    logic [15:0]       frames_r;
    logic [7:0]        ferrs_r, perrs_r;
    logic              unused_s;

    assign unused_s   = ctrl[CTRL_MON_EN] ^ sh_ctrl_r[CTRL_MON_EN];
    assign last_bit_s = {1'b0, sh_ctrl_r[CTRL_DBITS_LSB +: 2]} + 3'd4;

    // Two-flop synchroniser for the asynchronous transmit line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= line;
            sync2_r <= sync1_r;
        end
    end

    // Frame FSM next-state; START samples as its counter steps 1 -> 0.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        bit_idx_s   = bit_idx_r;
        par_s       = par_r;
        stop_idx_s  = stop_idx_r;
        ferr_seen_s = ferr_seen_r;
        sh_ctrl_s   = sh_ctrl_r;
        sh_div_s    = sh_div_r;
        err_s       = 1'b0;
        inc_frame_s = 1'b0;
        inc_ferr_s  = 1'b0;
        inc_perr_s  = 1'b0;
        if (!mon_en) begin
            state_s = MON_IDLE;
        end else begin
            case (state_r)
                MON_IDLE: begin
                    if (!sync2_r) begin
                        state_s   = MON_START;
                        cnt_s     = div >> 1;
                        sh_ctrl_s = ctrl;
                        sh_div_s  = div;
                    end else begin
                        state_s = MON_IDLE;
                    end
                end
                MON_START: begin
                    if (cnt_r <= DIV_W'(1)) begin
                        if (sync2_r) begin
                            state_s = MON_IDLE;
                        end else begin
                            state_s     = MON_DATA;
                            cnt_s       = sh_div_r - DIV_W'(1);
                            bit_idx_s   = 3'd0;
                            par_s       = 1'b0;
                            ferr_seen_s = 1'b0;
                        end
                    end else begin
                        cnt_s = cnt_r - DIV_W'(1);
                    end
                end
                MON_DATA: begin
                    if (cnt_r == '0) begin
                        cnt_s = sh_div_r - DIV_W'(1);
                        par_s = par_r ^ sync2_r;
                        if (bit_idx_r == last_bit_s) begin
                            state_s    = sh_ctrl_r[CTRL_PAR_EN] ? MON_PARITY : MON_STOP;
                            stop_idx_s = 1'b0;
                        end else begin
                            bit_idx_s = bit_idx_r + 3'd1;
                        end
                    end else begin
                        cnt_s = cnt_r - DIV_W'(1);
                    end
                end
                MON_PARITY: begin
                    if (cnt_r == '0) begin
                        cnt_s      = sh_div_r - DIV_W'(1);
                        state_s    = MON_STOP;
                        stop_idx_s = 1'b0;
                        if (sync2_r != parity_bit(par_r, sh_ctrl_r[CTRL_PAR_ODD])) begin
                            inc_perr_s = 1'b1;
                            err_s      = 1'b1;
                        end else begin
                            inc_perr_s = 1'b0;
                        end
                    end else begin
                        cnt_s = cnt_r - DIV_W'(1);
                    end
                end
                MON_STOP: begin
                    if (cnt_r == '0) begin
                        cnt_s = sh_div_r - DIV_W'(1);
                        if (!sync2_r && !ferr_seen_r) begin
                            inc_ferr_s  = 1'b1;
                            err_s       = 1'b1;
                            ferr_seen_s = 1'b1;
                        end else begin
                            inc_ferr_s = 1'b0;
                        end
                        if (stop_idx_r || !sh_ctrl_r[CTRL_STOP2]) begin
                            state_s     = MON_IDLE;
                            inc_frame_s = 1'b1;
                        end else begin
                            stop_idx_s = 1'b1;
                        end
                    end else begin
                        cnt_s = cnt_r - DIV_W'(1);
                    end
                end
                default: begin
                    state_s = MON_IDLE;
                end
            endcase
        end
    end

    // FSM, shadow and error-pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= MON_IDLE;
            cnt_r       <= '0;
            bit_idx_r   <= 3'd0;
            par_r       <= 1'b0;
            stop_idx_r  <= 1'b0;
            ferr_seen_r <= 1'b0;
            sh_ctrl_r   <= CTRL_RESET;
            sh_div_r    <= DIV_W'(DIV_RESET);
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            bit_idx_r   <= bit_idx_s;
            par_r       <= par_s;
            stop_idx_r  <= stop_idx_s;
            ferr_seen_r <= ferr_seen_s;
            sh_ctrl_r   <= sh_ctrl_s;
            sh_div_r    <= sh_div_s;
            err_r       <= err_s;
        end
    end

    // Saturating counters; a clear on the same cycle drops the increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frames_r <= 16'd0;
            ferrs_r  <= 8'd0;
            perrs_r  <= 8'd0;
        end else if (clr) begin
            frames_r <= 16'd0;
            ferrs_r  <= 8'd0;
            perrs_r  <= 8'd0;
        end else begin
            frames_r <= inc_frame_s ? sat_inc16(frames_r) : frames_r;
            ferrs_r  <= inc_ferr_s  ? sat_inc8(ferrs_r)   : ferrs_r;
            perrs_r  <= inc_perr_s  ? sat_inc8(perrs_r)   : perrs_r;
        end
    end

    assign frames    = frames_r;
    assign ferrs     = ferrs_r;
    assign perrs     = perrs_r;
    assign frame_err = err_r;

endmodule

// File: rtl/uart_link_xbar.sv
// N-channel UART line crossbar: APB register block, per-receive-line
// source selection with registered outputs, and one frame monitor per channel.
module uart_link_xbar
    import uart_xbar_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int DIV_W  = 16
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [31:0]       paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    input  logic [NUM_CH-1:0] uart_tx_i,
    output logic [NUM_CH-1:0] uart_rx_o,
    output logic [NUM_CH-1:0] frame_err_o
);

    logic [CTRL_W-1:0] ctrl_r;
    logic [DIV_W-1:0]  div_r;
    logic [DIV_W-1:0]  wdiv_s;
    logic [7:0]        route_r [NUM_CH];
    logic [NUM_CH-1:0] rx_r, rx_next_s;
    logic [NUM_CH-1:0] route_we_s, clr_s, frame_err_s;
    logic [15:0]       frames_s [NUM_CH];
    logic [7:0]        ferrs_s  [NUM_CH];
    logic [7:0]        perrs_s  [NUM_CH];
    logic              access_s, hit_s, ctrl_we_s, div_we_s;
    logic [7:0]        addr_s;
    logic [31:0]       rdata_s;
    logic              unused_s;

    assign access_s = psel & penable;
    assign addr_s   = paddr[7:0];
    assign wdiv_s   = pwdata[DIV_W-1:0];
    assign unused_s = ^{paddr, pwdata};

    // Address decode, read mux and write strobes for the access phase.
    always_comb begin
        hit_s      = 1'b0;
        rdata_s    = 32'd0;
        ctrl_we_s  = 1'b0;
        div_we_s   = 1'b0;
        route_we_s = '0;
        clr_s      = '0;
        if (addr_s == ADDR_CTRL) begin
            hit_s     = 1'b1;
            rdata_s   = 32'(ctrl_r);
            ctrl_we_s = access_s & pwrite;
        end else if (addr_s == ADDR_DIV) begin
            hit_s    = 1'b1;
            rdata_s  = 32'(div_r);
            div_we_s = access_s & pwrite;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (addr_s == ADDR_ROUTE_BASE + 8'(4 * k)) begin
                    hit_s         = 1'b1;
                    rdata_s       = 32'(route_r[k]);
                    route_we_s[k] = access_s & pwrite;
                end else if (addr_s == ADDR_STAT_BASE + 8'(4 * k)) begin
                    hit_s    = 1'b1;
                    rdata_s  = {perrs_s[k], ferrs_s[k], frames_s[k]};
                    clr_s[k] = access_s & pwrite;
                end else begin
                    hit_s = hit_s;
                end
            end
        end
        if (access_s && !pwrite && hit_s) begin
            prdata = rdata_s;
        end else begin
            prdata = 32'd0;
        end
        pslverr = access_s & ~hit_s;
    end

    assign pready = 1'b1;

    // Configuration registers; DIV is clamped to the minimum usable divisor.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            ctrl_r <= CTRL_RESET;
            div_r  <= DIV_W'(DIV_RESET);
            for (int k = 0; k < NUM_CH; k++) begin
                route_r[k] <= 8'(k ^ 1);
            end
        end else begin
            if (ctrl_we_s) begin
                ctrl_r <= pwdata[CTRL_W-1:0];
            end else begin
                ctrl_r <= ctrl_r;
            end
            if (div_we_s) begin
                div_r <= (wdiv_s < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : wdiv_s;
            end else begin
                div_r <= div_r;
            end
            for (int k = 0; k < NUM_CH; k++) begin
                if (route_we_s[k]) begin
                    route_r[k] <= pwdata[7:0];
                end else begin
                    route_r[k] <= route_r[k];
                end
            end
        end
    end

    // Source select per receive line; out-of-range sources idle high.
    always_comb begin
        rx_next_s = '1;
        for (int k = 0; k < NUM_CH; k++) begin
            for (int j = 0; j < NUM_CH; j++) begin
                if (route_r[k] == 8'(j)) begin
                    rx_next_s[k] = uart_tx_i[j];
                end else begin
                    rx_next_s[k] = rx_next_s[k];
                end
            end
        end
    end

    // Registered receive-line outputs.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            rx_r <= '1;
        end else begin
            rx_r <= rx_next_s;
        end
    end

    assign uart_rx_o   = rx_r;
    assign frame_err_o = frame_err_s;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_mon
        uart_frame_mon #(
            .DIV_W (DIV_W)
        ) u_mon (
            .clk       (pclk),
            .rst       (preset),
            .line      (uart_tx_i[g]),
            .mon_en    (ctrl_r[CTRL_MON_EN]),
            .ctrl      (ctrl_r),
            .div       (div_r),
            .clr       (clr_s[g]),
            .frames    (frames_s[g]),
            .ferrs     (ferrs_s[g]),
            .perrs     (perrs_s[g]),
            .frame_err (frame_err_s[g])
        );
    end

endmodule

// File: tb/tb_uart_link_xbar.sv
// Scoreboard bench for uart_link_xbar (NUM_CH=4): APB reads push expected
// values, a negedge monitor pops and compares them during the access phase.
module tb_uart_link_xbar;

    localparam int NCH    = 4;
    localparam int TB_DIV = 16;

    logic            pclk = 1'b0;
    logic            preset;
    logic            psel, penable, pwrite;
    logic [31:0]     paddr, pwdata, prdata;
    logic            pready, pslverr;
    logic [NCH-1:0]  tx, uart_rx_o, frame_err_o;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   pulse_cnt [NCH];

    uart_link_xbar #(.NUM_CH(NCH), .DIV_W(16)) dut (
        .pclk        (pclk),
        .preset      (preset),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .prdata      (prdata),
        .pready      (pready),
        .pslverr     (pslverr),
        .uart_tx_i   (tx),
        .uart_rx_o   (uart_rx_o),
        .frame_err_o (frame_err_o)
    );

    always #5 pclk = ~pclk;

    // Read-data monitor: compares every APB read against the scoreboard.
    always @(negedge pclk) begin
        if (psel && penable && !pwrite) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL apb_unexpected_read: addr=%h prdata=%h", paddr, prdata);
            end else begin
                exp_t it;
                it = exp_q.pop_front();
                if (prdata !== it.data || pslverr !== it.err) begin
                    errors++;
                    $display("FAIL %s: got prdata=%h pslverr=%b, expected prdata=%h pslverr=%b",
                             it.name, prdata, pslverr, it.data, it.err);
                end
            end
        end
    end

    // Counts high cycles of each frame_err_o bit.
    always @(posedge pclk) begin
        for (int k = 0; k < NCH; k++) begin
            if (frame_err_o[k] === 1'b1) pulse_cnt[k]++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a, input logic [31:0] exp, input logic err,
                            input string name);
        exp_t it;
        it.name = name; it.data = exp; it.err = err;
        exp_q.push_back(it);
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    // Drives one bit time (called and returns at posedge+1); optionally checks
    // that the partner receive line is one cycle behind.
    task automatic drive_bit(input int ch, input logic val, input int cycles, input bit chk);
        logic prev;
        prev = tx[ch];
        tx[ch] = val;
        if (chk) begin
            #1;
            check("rx_hold", 32'(uart_rx_o[ch ^ 1]), 32'(prev));
        end
        @(posedge pclk); #1;
        if (chk) check("rx_follow", 32'(uart_rx_o[ch ^ 1]), 32'(val));
        repeat (cycles - 1) @(posedge pclk);
        #1;
    endtask

    task automatic send_frame(input int ch, input logic [7:0] data, input int nbits,
                              input bit par_en, input bit par_odd, input bit flip_par,
                              input bit bad_stop, input bit chk);
        logic p;
        p = par_odd;
        drive_bit(ch, 1'b0, TB_DIV, chk);
        for (int i = 0; i < nbits; i++) begin
            drive_bit(ch, data[i], TB_DIV, chk);
            p = p ^ data[i];
        end
        if (par_en) drive_bit(ch, p ^ flip_par, TB_DIV, chk);
        // A short low stop bit so the line is high again before the follow-on
        // false start is sampled.
        if (bad_stop) drive_bit(ch, 1'b0, TB_DIV / 2 + 4, chk);
        else          drive_bit(ch, 1'b1, TB_DIV, chk);
        drive_bit(ch, 1'b1, 20, chk);
    endtask

    initial begin
        int base;
        preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 32'd0; pwdata = 32'd0; tx = '1;
        repeat (3) @(posedge pclk);
        #1;
        check("reset_rx", 32'(uart_rx_o), 32'hF);
        check("reset_ferr", 32'(frame_err_o), 32'h0);
        check("reset_prdata", prdata, 32'h0);
        check("reset_pslverr", 32'(pslverr), 32'h0);
        preset = 1'b0;

        apb_read(32'h00, 32'h06, 1'b0, "ctrl_reset");
        apb_read(32'h04, 32'd16, 1'b0, "div_reset");
        apb_read(32'h08, 32'd1, 1'b0, "route0_reset");
        apb_read(32'h0C, 32'd0, 1'b0, "route1_reset");
        apb_read(32'h10, 32'd3, 1'b0, "route2_reset");
        apb_read(32'h14, 32'd2, 1'b0, "route3_reset");
        apb_read(32'h40, 32'd0, 1'b0, "stat0_reset");

        // 8N1 frame 0x55 on channel 0, routed to receive line 1.
        apb_write(32'h00, 32'h07);
        send_frame(0, 8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        apb_read(32'h40, 32'h0000_0001, 1'b0, "stat0_8n1");
        check("pulses_ch0_clean", 32'(pulse_cnt[0]), 32'd0);

        // Rerouting: rx1 <- tx2, rx0 out of range.
        apb_write(32'h0C, 32'd2);
        apb_write(32'h08, 32'd7);
        apb_read(32'h0C, 32'd2, 1'b0, "route1_rb");
        apb_read(32'h08, 32'd7, 1'b0, "route0_rb");
        tx = 4'b0000;
        repeat (2) @(posedge pclk); #1;
        check("route_rx1_low", 32'(uart_rx_o[1]), 32'd0);
        check("route_rx0_idle_low", 32'(uart_rx_o[0]), 32'd1);
        tx = 4'b0100;
        repeat (2) @(posedge pclk); #1;
        check("route_rx1_high", 32'(uart_rx_o[1]), 32'd1);
        tx = 4'b1011;
        repeat (2) @(posedge pclk); #1;
        check("route_rx1_low2", 32'(uart_rx_o[1]), 32'd0);
        check("route_rx0_idle", 32'(uart_rx_o[0]), 32'd1);
        tx = 4'b1111;
        apb_write(32'h08, 32'd1);
        apb_write(32'h0C, 32'd0);
        repeat (30) @(posedge pclk); #1;
        apb_read(32'h48, 32'd0, 1'b0, "stat2_after_short_lows");

        // Framing error on channel 1, then clear.
        base = pulse_cnt[1];
        send_frame(1, 8'hA3, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (40) @(posedge pclk); #1;
        check("pulses_ch1_ferr", 32'(pulse_cnt[1] - base), 32'd1);
        apb_read(32'h44, 32'h0001_0001, 1'b0, "stat1_ferr");
        apb_write(32'h44, 32'h0);
        apb_read(32'h44, 32'h0, 1'b0, "stat1_cleared");

        // 7E1: flipped parity then correct parity on channel 2.
        apb_write(32'h00, 32'h0D);
        base = pulse_cnt[2];
        send_frame(2, 8'h41, 7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("pulses_ch2_perr", 32'(pulse_cnt[2] - base), 32'd1);
        apb_read(32'h48, 32'h0100_0001, 1'b0, "stat2_perr");
        send_frame(2, 8'h41, 7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        apb_read(32'h48, 32'h0100_0002, 1'b0, "stat2_good");
        check("pulses_ch2_total", 32'(pulse_cnt[2] - base), 32'd1);

        // Glitch of DIV/4 cycles on channel 3.
        drive_bit(3, 1'b0, TB_DIV / 4, 1'b0);
        drive_bit(3, 1'b1, 40, 1'b0);
        apb_read(32'h4C, 32'h0, 1'b0, "stat3_glitch");
        check("pulses_ch3", 32'(pulse_cnt[3]), 32'd0);

        // Reset in the middle of a frame on channel 2.
        tx[2] = 1'b0;
        repeat (30) @(posedge pclk); #1;
        preset = 1'b1;
        repeat (3) @(posedge pclk); #1;
        preset = 1'b0;
        tx[2] = 1'b1;
        apb_read(32'h48, 32'h0, 1'b0, "stat2_after_reset");
        apb_read(32'h00, 32'h06, 1'b0, "ctrl_after_reset");
        apb_write(32'h00, 32'h07);
        send_frame(0, 8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        apb_read(32'h40, 32'h0000_0001, 1'b0, "stat0_after_reset");
        apb_read(32'h48, 32'h0, 1'b0, "stat2_no_frame");

        // Unmapped addresses and DIV clamp.
        apb_read(32'h30, 32'h0, 1'b1, "unmapped_0x30");
        apb_read(32'h50, 32'h0, 1'b1, "unmapped_stat4");
        apb_write(32'h04, 32'd2);
        apb_read(32'h04, 32'd4, 1'b0, "div_clamp");
        apb_write(32'h04, 32'd5);
        apb_read(32'h04, 32'd5, 1'b0, "div_5");

        repeat (5) @(posedge pclk); #1;
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
